pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline controller for the four-stage core. It merges stall requests from fetch, decode, execute and the load/store unit. It turns branch/jump resolutions and trap requests into flush commands with redirect addresses. It drives the `stall` and `flush` inputs of every pipeline register (PC, IF→ID, ID→EX) and keeps a performance counter of stalled cycles.

## Interface
- `CNT_W`, default 32: width of the stall-cycle counter.
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ifu_wait_i` in 1: fetch response not yet returned (level).
- `ld_use_i` in 1: ID needs the rd of a load currently in EX (level).
- `ex_busy_i` in 1: multi-cycle EX op (div/rem) not finished (level).
- `mem_wait_i` in 1: LSU access outstanding (level).
- `jump_req_i` in 1: EX resolved a taken branch/jal/jalr.
- `jump_addr_i` in 32: jump target.
- `trap_req_i` in 1: interrupt/exception request; held high until acknowledged.
- `trap_addr_i` in 32: trap vector; stable while `trap_req_i`=1.
- `cnt_clr_i` in 1: clear stall counter.
- `stall_o` out `STALL_WIDTH`: per-stage hold, bits `STALL_PC`, `STALL_IF`, `STALL_ID`, `STALL_EX`.
- `bubble_ex_o` out 1: ID→EX register loads a NOP (zeroes) this cycle.
- `flush_o` out 1: flush IF/ID/EX registers and redirect PC.
- `flush_addr_o` out 32: redirect target; 0 when `flush_o`=0.
- `trap_ack_o` out 1: one-cycle pulse; trap accepted.
- `stall_cnt_o` out `CNT_W`: count of cycles with `stall_o[STALL_PC]`=1.

## Operation
- FSM states: IDLE, TRAP_WAIT, TRAP_FIRE. Reset state is IDLE.
- IDLE, with `trap_req_i`=1:
  - Go to TRAP_FIRE if `ex_busy_i`=0 and `mem_wait_i`=0.
  - Otherwise go to TRAP_WAIT.
  - In the detection cycle, `stall_o`=1111 and `jump_req_i` is ignored.
- TRAP_WAIT: `stall_o`=1111. Go to TRAP_FIRE in the first cycle where `ex_busy_i`=0 and `mem_wait_i`=0.
- TRAP_FIRE (exactly one cycle):
  - `flush_o`=1, `flush_addr_o`=`trap_addr_i`, `trap_ack_o`=1, `stall_o`=0000.
  - Then go to IDLE.
  - A concurrent `jump_req_i` is dropped.
- IDLE, no trap: combinational priority, highest first:
  1. `ex_busy_i` | `mem_wait_i` → `stall_o`=1111. Jumps are not accepted, because EX is held and re-presents the jump.
  2. `jump_req_i` → `flush_o`=1, `flush_addr_o`=`jump_addr_i`, `stall_o`=0000. The flush overrides `ld_use_i` and `ifu_wait_i`.
  3. `ld_use_i` → `stall_o`=0111 (PC, IF, ID held), `bubble_ex_o`=1.
  4. `ifu_wait_i` → `stall_o`=0001 (PC held).
  5. Otherwise all outputs are 0.
- `bubble_ex_o` is 1 only in case 3.
- `trap_ack_o` is 1 only in TRAP_FIRE.
- Counter:
  - `cnt_clr_i`=1 → 0. Clear beats increment.
  - Else, if `stall_o[STALL_PC]`=1 → +1, saturating at all-ones.
- `rst`=1 (including mid-operation, e.g. in TRAP_WAIT):
  - Next cycle: state IDLE, counter 0.
  - A pending trap is not acknowledged. It re-enters through IDLE if `trap_req_i` is still high.

## Timing
- Reset values, with all inputs at 0: `stall_o`=0, `bubble_ex_o`=0, `flush_o`=0, `flush_addr_o`=0, `trap_ack_o`=0, `stall_cnt_o`=0.
- `stall_o`, `bubble_ex_o`, `flush_o` and `flush_addr_o` are combinational from the state and the inputs, with zero latency. Pipeline registers act on them at the same edge.
- Jump: flush is in the same cycle as `jump_req_i` when nothing stalls the pipe.
- Trap latency: `trap_ack_o` rises 1 cycle after `trap_req_i` if the pipe is idle. Otherwise it rises 1 cycle after busy/wait drops.
- `stall_cnt_o` is registered. It reflects stalls up to the previous cycle.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `ex_busy_i`=1 and `trap_req_i`=1, then release with all inputs at 0 → `stall_cnt_o`=0, state IDLE, `trap_ack_o` never pulses.
- **Jump:** `jump_req_i`=1, `jump_addr_i`=0x0000_0100, `ld_use_i`=1 → same cycle `flush_o`=1, `flush_addr_o`=0x100, `stall_o`=0000, `bubble_ex_o`=0.
- **Load-use then stall:**
  - `ld_use_i`=1 for 1 cycle → `stall_o`=0111, `bubble_ex_o`=1.
  - Then `ex_busy_i`=1 for 3 cycles → `stall_o`=1111 ×3.
  - `stall_cnt_o` reads 4 one cycle later.
  - `jump_req_i` held during busy → no flush until busy drops.
- **Trap drain:**
  - `mem_wait_i`=1 for 5 cycles, `trap_req_i`=1 from cycle 2, `trap_addr_i`=0x8000_0004.
  - Expect TRAP_WAIT with `stall_o`=1111.
  - `trap_ack_o`, `flush_o`=1 and `flush_addr_o`=0x8000_0004 occur exactly one cycle after `mem_wait_i` falls.
  - A `jump_req_i` in that cycle is ignored.
- **Counter saturation and clear:**
  - `CNT_W`=4, stall for 20 cycles → `stall_cnt_o`=0xF.
  - `cnt_clr_i`=1 together with a stall → counter 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stall sources, turns jumps and traps into
// flush/redirect commands, and counts cycles in which the PC is held.
module pipe_ctrl #(
    parameter int CNT_W       = 32,
    parameter int STALL_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ifu_wait_i,
    input  logic                   ld_use_i,
    input  logic                   ex_busy_i,
    input  logic                   mem_wait_i,
    input  logic                   jump_req_i,
    input  logic [31:0]            jump_addr_i,
    input  logic                   trap_req_i,
    input  logic [31:0]            trap_addr_i,
    input  logic                   cnt_clr_i,
    output logic [STALL_WIDTH-1:0] stall_o,
    output logic                   bubble_ex_o,
    output logic                   flush_o,
    output logic [31:0]            flush_addr_o,
    output logic                   trap_ack_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    // Bit positions in stall_o: PC=0, IF=1, ID=2, EX=3.
    localparam int STALL_PC = 0;

    localparam logic [STALL_WIDTH-1:0] STALL_NONE  = 4'b0000;
    localparam logic [STALL_WIDTH-1:0] STALL_ALL   = 4'b1111;
    localparam logic [STALL_WIDTH-1:0] STALL_LDUSE = 4'b0111;
    localparam logic [STALL_WIDTH-1:0] STALL_FETCH = 4'b0001;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRAP_WAIT = 2'd1,
        ST_TRAP_FIRE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    trap_ack_r;
    logic [CNT_W-1:0]        stall_cnt_r;

    logic                    drain_s;
    logic [STALL_WIDTH-1:0]  stall_s;
    logic                    bubble_s;
    logic                    flush_s;
    logic [31:0]             flush_addr_s;

    // Back-end still owns the pipe while a multi-cycle EX op or LSU access is open.
    assign drain_s = ex_busy_i | mem_wait_i;

    // Zero-latency hazard resolution and next-state selection.
    always_comb begin
        state_nxt_s  = state_r;
        stall_s      = STALL_NONE;
        bubble_s     = 1'b0;
        flush_s      = 1'b0;
        flush_addr_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (trap_req_i) begin
                    // Trap detection freezes everything; any jump is discarded.
                    stall_s = STALL_ALL;
                    if (drain_s) begin
                        state_nxt_s = ST_TRAP_WAIT;
                    end else begin
                        state_nxt_s = ST_TRAP_FIRE;
                    end
                end else if (drain_s) begin
                    // EX is held, so a pending jump is re-presented later.
                    stall_s = STALL_ALL;
                end else if (jump_req_i) begin
                    flush_s      = 1'b1;
                    flush_addr_s = jump_addr_i;
                end else if (ld_use_i) begin
                    stall_s  = STALL_LDUSE;
                    bubble_s = 1'b1;
                end else if (ifu_wait_i) begin
                    stall_s = STALL_FETCH;
                end else begin
                    stall_s = STALL_NONE;
                end
            end
            ST_TRAP_WAIT: begin
                stall_s = STALL_ALL;
                if (drain_s) begin
                    state_nxt_s = ST_TRAP_WAIT;
                end else begin
                    state_nxt_s = ST_TRAP_FIRE;
                end
            end
            ST_TRAP_FIRE: begin
                flush_s      = 1'b1;
                flush_addr_s = trap_addr_i;
                state_nxt_s  = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state and the registered trap acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            trap_ack_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            trap_ack_r <= (state_nxt_s == ST_TRAP_FIRE);
        end
    end

    // Saturating count of PC-hold cycles; a clear wins over an increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s[STALL_PC] && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_o      = stall_s;
    assign bubble_ex_o  = bubble_s;
    assign flush_o      = flush_s;
    assign flush_addr_o = flush_addr_s;
    assign trap_ack_o   = trap_ack_r;
    assign stall_cnt_o  = stall_cnt_r;

endmodule
